// File: rtl/irq_ctrl_if.sv
// Peripheral bus bundle between the CPU (master) and the interrupt controller (slave).
// addr is the full 8-bit bus address; only the slave decides which bits it decodes.
interface irq_ctrl_if;
  logic [7:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wr_en;
  logic       rd_en;

  modport master (
    output addr,
    output din,
    output wr_en,
    output rd_en,
    input  dout
  );

  modport slave (
    input  addr,
    input  din,
    input  wr_en,
    input  rd_en,
    output dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller driving the CPU irq pin.
// Collects NUM_SRC asynchronous sources, synchronizes them, latches edge or level
// pending bits, masks them and arbitrates one request that is held in service
// until the CPU writes end-of-interrupt (any write to VEC).
// Register map (addr[1:0]): 0 PEND (W1C, edge sources), 1 MASK, 2 MODE (1 = edge),
// 3 VEC = {active, 4'b0, id}; a write to VEC is the EOI.
// Optional feature macro: IRQ_CTRL_ROUND_ROBIN_EN selects rotating priority;
// when undefined the lowest source index always wins.
module irq_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Synchronizer chain plus one delayed copy of its last stage for edge detection
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] dly_q;
  logic [NUM_SRC-1:0] lvl;
  logic [NUM_SRC-1:0] rise;

  // Architectural registers
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] mode_prev_q;
  logic [NUM_SRC-1:0] mode_chg;
  logic [NUM_SRC-1:0] req;

  // Service state machine
  state_t     state_q, state_d;
  logic [2:0] id_q, id_d;
  logic       irq_q, irq_d;
  logic [2:0] start;
  logic [2:0] winner;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [2:0] last_q, last_d;
`endif

  // Bus decode
  logic       wr_pend, wr_mask, wr_mode, eoi;
  logic [7:0] rdata;
  logic       bus_unused;

  // First set bit of r searching upward from index start, wrapping at NUM_SRC.
  function automatic logic [2:0] pick(input logic [NUM_SRC-1:0] r, input logic [2:0] from);
    logic [2:0] w;
    logic       found;
    int         idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(from) + k) % NUM_SRC;
      if (!found && r[idx]) begin
        w     = 3'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign wr_pend = bus.wr_en && (bus.addr[1:0] == 2'd0);
  assign wr_mask = bus.wr_en && (bus.addr[1:0] == 2'd1);
  assign wr_mode = bus.wr_en && (bus.addr[1:0] == 2'd2);
  assign eoi     = bus.wr_en && (bus.addr[1:0] == 2'd3);

  // Upper address bits are range-decoded outside; upper data bits may be unused
  assign bus_unused = ^{bus.addr[7:2], bus.din};

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign rise     = lvl & ~dly_q;
  assign mode_chg = mode_q ^ mode_prev_q;
  assign req      = pend_q & mask_q;
  assign irq      = irq_q;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  assign start = 3'((int'(last_q) + 1) % NUM_SRC);
`else
  assign start = 3'd0;
`endif

  assign winner = pick(req, start);

  // Bring the asynchronous sources into the clk domain and keep the previous level
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      dly_q <= lvl;
    end
  end

  // MASK and MODE are plain read/write registers
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_mask) mask_d = bus.din[NUM_SRC-1:0];
    if (wr_mode) mode_d = bus.din[NUM_SRC-1:0];
  end

  // Pending bits: edge sources latch rises (set beats clear), level sources mirror
  // the synchronized line, and any bit whose MODE just changed is flushed once.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_chg[i]) begin
        pend_d[i] = 1'b0;
      end else if (mode_q[i]) begin
        if (rise[i]) begin
          pend_d[i] = 1'b1;
        end else if ((wr_pend && bus.din[i]) ||
                     (eoi && (state_q == ACTIVE) && (id_q == 3'(i)))) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = lvl[i];
      end
    end
  end

  // Register file update
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      mode_prev_q <= '0;
    end else begin
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      mode_prev_q <= mode_q;
    end
  end

  // Service FSM next state: arbitrate in IDLE, hold in ACTIVE until EOI, one dead GAP cycle
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    irq_d   = 1'b0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACTIVE;
          id_d    = winner;
          irq_d   = 1'b1;
        end
      end
      ACTIVE: begin
        irq_d = 1'b1;
        if (eoi) begin
          state_d = GAP;
          irq_d   = 1'b0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
          last_d  = id_q;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Service FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      last_q  <= 3'(NUM_SRC - 1);
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Combinational read mux; reads during a write show the pre-write value
  always_comb begin
    rdata = '0;
    case (bus.addr[1:0])
      2'd0:    rdata = 8'(pend_q);
      2'd1:    rdata = 8'(mask_q);
      2'd2:    rdata = 8'(mode_q);
      default: rdata = {(state_q == ACTIVE), 4'b0000, id_q};
    endcase
  end

  assign bus.dout = bus.rd_en ? rdata : 8'h00;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed table-driven bench for irq_ctrl (NUM_SRC=4, SYNC_STAGES=2).
// Each table row is driven for one clock; dout and irq are checked after the
// inputs settle and before the row's rising edge, so a row's expectations
// reflect the state produced by all earlier rows.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src;
  logic       irq;

  irq_ctrl_if bus();

  irq_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [1:0] a;
    logic [7:0] d;
    logic [3:0] s;
    logic [7:0] edo;
    logic       eirq;
  } vec_t;

  vec_t tv[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic r, logic w, logic rd, logic [1:0] a, logic [7:0] d,
                              logic [3:0] s, logic [7:0] edo, logic eirq);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.a = a; v.d = d; v.s = s; v.edo = edo; v.eirq = eirq;
    return v;
  endfunction

  task automatic drive(logic r, logic w, logic rd, logic [1:0] a, logic [7:0] d, logic [3:0] s);
    reset      = r;
    bus.wr_en  = w;
    bus.rd_en  = rd;
    bus.addr   = {6'b101010, a};
    bus.din    = d;
    src        = s;
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic wait_irq(string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 2'd0, 8'h00, 4'h3);
      #1;
      if (irq === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: got irq=0 after 16 cycles want irq=1", name);
    end
  endtask

  logic [2:0] rr_exp [3];

  initial begin
    //        rst wr rd  a     din    src   dout  irq
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h00, 0)); // 0 reset reads
    tv.push_back(mk(0, 0, 1, 2'd1, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd2, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 1, 0, 2'd1, 8'h0F, 4'h0, 8'h00, 0)); // 4 MASK=0F
    tv.push_back(mk(0, 1, 0, 2'd2, 8'h01, 4'h0, 8'h00, 0)); // 5 MODE=01
    tv.push_back(mk(0, 0, 1, 2'd2, 8'h00, 4'h0, 8'h01, 0));
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h1, 8'h00, 0)); // 7 src0 pulse
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h01, 0)); // 10 pending, irq not yet
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h80, 1)); // 11 irq 4 edges after pulse
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h0, 8'h00, 1)); // 12 EOI
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h00, 0)); // 13 irq low, PEND cleared
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 1, 0, 2'd2, 8'h00, 4'h0, 8'h00, 0)); // 15 MODE=00
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h6, 8'h00, 0)); // 16 levels 1,2 high
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h6, 8'h00, 0));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h6, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h6, 8'h06, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h6, 8'h81, 1)); // 20 id 1 wins
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h6, 8'h00, 1)); // 21 EOI, src1 still high
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h6, 8'h01, 0)); // 22 GAP
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h6, 8'h00, 0)); // 23 IDLE
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h6, 8'h81, 1)); // 24 back 3 cycles after EOI
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h4, 8'h00, 1)); // 25 drop src1
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h4, 8'h00, 1));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h4, 8'h00, 1));
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h4, 8'h00, 1)); // 28 EOI
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h4, 8'h00, 0));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h4, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h4, 8'h82, 1)); // 31 id 2
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 1)); // 32 drop src2, still held
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 1));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 1));
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h0, 8'h00, 1)); // 35 EOI
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h02, 0)); // 38 id kept, inactive
    tv.push_back(mk(0, 1, 0, 2'd1, 8'h00, 4'h0, 8'h00, 0)); // 39 MASK=00
    tv.push_back(mk(0, 1, 0, 2'd2, 8'h08, 4'h0, 8'h00, 0)); // 40 MODE=08
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h8, 8'h00, 0)); // 41 src3 pulse
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h08, 0)); // 44 pending but masked
    tv.push_back(mk(0, 1, 0, 2'd1, 8'h08, 4'h0, 8'h00, 0)); // 45 MASK=08
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h83, 1)); // 47 id 3
    tv.push_back(mk(0, 1, 0, 2'd0, 8'h08, 4'h0, 8'h00, 1)); // 48 W1C during ACTIVE
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h0, 8'h00, 1));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h83, 1)); // 50 still held
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h0, 8'h00, 1)); // 51 EOI
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 1, 0, 2'd1, 8'h00, 4'h0, 8'h00, 0)); // 53 MASK=00
    tv.push_back(mk(0, 1, 0, 2'd2, 8'h09, 4'h0, 8'h00, 0)); // 54 MODE=09
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h1, 8'h00, 0)); // 55 src0 rises
    tv.push_back(mk(0, 0, 0, 2'd0, 8'h00, 4'h1, 8'h00, 0));
    tv.push_back(mk(0, 1, 0, 2'd0, 8'h01, 4'h1, 8'h00, 0)); // 57 W1C on the rise cycle
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h1, 8'h01, 0)); // 58 set won
    tv.push_back(mk(0, 1, 0, 2'd0, 8'h01, 4'h3, 8'h00, 0)); // 59 clear bit0
    tv.push_back(mk(0, 1, 0, 2'd1, 8'h02, 4'h3, 8'h00, 0)); // 60 MASK=02
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h3, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd0, 8'h00, 4'h3, 8'h02, 0));
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h3, 8'h81, 1)); // 63 ACTIVE id 1
    tv.push_back(mk(1, 0, 1, 2'd1, 8'h00, 4'h3, 8'h02, 1)); // 64 reset mid-ACTIVE
    tv.push_back(mk(0, 0, 1, 2'd1, 8'h00, 4'h0, 8'h00, 0)); // 65 irq 0, MASK 0
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 0, 1, 2'd2, 8'h00, 4'h0, 8'h00, 0));
    tv.push_back(mk(0, 1, 1, 2'd1, 8'h05, 4'h0, 8'h00, 0)); // 68 read+write: old value
    tv.push_back(mk(0, 0, 1, 2'd1, 8'h00, 4'h0, 8'h05, 0));
    tv.push_back(mk(0, 1, 0, 2'd3, 8'h00, 4'h0, 8'h00, 0)); // 70 EOI while IDLE
    tv.push_back(mk(0, 0, 1, 2'd3, 8'h00, 4'h0, 8'h00, 0));

    drive(1, 0, 0, 2'd0, 8'h00, 4'h0);
    repeat (3) @(negedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].wr, tv[i].rd, tv[i].a, tv[i].d, tv[i].s);
      #1;
      check($sformatf("row%0d dout", i), bus.dout, tv[i].edo);
      check($sformatf("row%0d irq", i), {7'd0, irq}, {7'd0, tv[i].eirq});
    end

    // Two level sources held high: order of service across three EOIs
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd0;
`else
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd0; rr_exp[2] = 3'd0;
`endif
    @(negedge clk);
    drive(0, 1, 0, 2'd1, 8'h03, 4'h3);
    for (int j = 0; j < 3; j++) begin
      wait_irq($sformatf("svc%0d irq", j));
      @(negedge clk);
      drive(0, 0, 1, 2'd3, 8'h00, 4'h3);
      #1;
      check($sformatf("svc%0d vec", j), bus.dout, {1'b1, 4'b0000, rr_exp[j]});
      @(negedge clk);
      drive(0, 1, 0, 2'd3, 8'h00, 4'h3);
      @(negedge clk);
      drive(0, 0, 0, 2'd0, 8'h00, 4'h3);
      #1;
      check($sformatf("svc%0d eoi irq", j), {7'd0, irq}, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
